// File: rtl/pipe_mux_n_pkg.sv
// Shared helpers for the registered N:1 select pipeline.
// sel_mux works on a maximally sized flat bus so one function serves every WIDTH/NUM_IN.
package pipe_mux_n_pkg;

  localparam int MAX_IN    = 16;
  localparam int MAX_W     = 64;
  localparam int MAX_SEL_W = 4;
  localparam int FLAT_W    = MAX_IN * MAX_W;

  // Returns {err, data}; an index past num_in yields zero data with err set.
  function automatic logic [MAX_W:0] sel_mux(
    input logic [MAX_SEL_W-1:0] sel,
    input logic [FLAT_W-1:0]    in_flat,
    input int                   num_in,
    input int                   width
  );
    logic [MAX_W:0] res;
    logic [9:0]     idx;
    logic [6:0]     bi;
    res = '0;
    idx = '0;
    bi  = '0;
    if (int'(sel) >= num_in) begin
      res[MAX_W] = 1'b1;
    end else begin
      for (int b = 0; b < MAX_W; b++) begin
        if (b < width) begin
          idx     = 10'(int'(sel) * width + b);
          bi      = 7'(b);
          res[bi] = in_flat[idx];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_mux_n_if.sv
// Upstream/downstream handshake bundle of pipe_mux_n.
// The master side drives select, data and out_ready; the block is the slave.
interface pipe_mux_n_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3
);

  localparam int SEL_W = $clog2(NUM_IN);

  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_flat;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output sel, in_flat, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  modport slave (
    input  sel, in_flat, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );

endinterface

// File: rtl/pipe_mux_n_skid.sv
// Generic two-slot valid/ready buffer: an output register plus one skid register.
// in_ready is registered so there is no combinational path from out_ready.
module skid_reg #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  occ_t         state, state_next;
  logic [W-1:0] out_q, skid_q;
  logic         acc, drn, load_out, load_skid, skid_to_out;

  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = out_q;

  always_comb begin
    state_next  = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state)
      EMPTY: begin
        if (acc) begin
          state_next = ONE;
          load_out   = 1'b1;
        end
      end
      ONE: begin
        if (acc && !drn) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (drn && !acc) begin
          state_next = EMPTY;
        end else if (acc && drn) begin
          load_out = 1'b1;
        end
      end
      FULL: begin
        if (drn) begin
          state_next  = ONE;
          skid_to_out = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // in_ready comes up one cycle after reset release and drops only while both slots hold beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != FULL);
      if (load_out) begin
        out_q <= in_data;
      end else if (skid_to_out) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_mux_n.sv
// Registered N:1 selector: combinational select, two-slot skid output, saturating beat counter.
module pipe_mux_n
  import pipe_mux_n_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] beat_cnt,
  pipe_mux_n_if.slave      bus
);

  logic [MAX_W:0] mux_res;
  logic [WIDTH:0] skid_out;
  logic           in_ready, out_valid, acc;
  logic           unused_ok;

  assign mux_res   = sel_mux(MAX_SEL_W'(bus.sel), FLAT_W'(bus.in_flat), NUM_IN, WIDTH);
  assign unused_ok = ^mux_res;

  skid_reg #(.W(WIDTH + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({mux_res[MAX_W], mux_res[WIDTH-1:0]}),
    .in_valid  (bus.in_valid),
    .in_ready  (in_ready),
    .out_data  (skid_out),
    .out_valid (out_valid),
    .out_ready (bus.out_ready)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_err   = skid_out[WIDTH];
  assign bus.out_data  = skid_out[WIDTH-1:0];
  assign acc           = bus.in_valid & in_ready;

  // Clear wins over a same-cycle accept; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (clr_cnt) begin
      beat_cnt <= '0;
    end else if (acc && (beat_cnt != '1)) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule
